// File: rtl/bram_stream_reader.sv
// Streams a burst of BRAM words out through a 2-entry skid FIFO with valid/ready handshake.
// Define BRAM_STREAM_READER_LAST_EN to add the m_last end-of-burst marker.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef BRAM_STREAM_READER_LAST_EN
  ,
  output logic                  m_last
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for start; first read issued in the start cycle
  // S_READ  | issuing remaining reads as FIFO space allows
  // S_DRAIN | all reads issued, emptying the FIFO
  // S_DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q;
  logic [1:0]            level;
  logic                  issue, push, pop, space_ok;

  assign push    = inflight_q;
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = mem_q[rd_ptr_q];
  assign pop     = m_valid & m_ready;
  // Count the beat leaving this cycle so a full pipeline keeps one beat per cycle.
  assign level    = occ_q - 2'(pop) + 2'(inflight_q);
  assign space_ok = (level <= 2'd1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    issue      = 1'b0;
    bram_raddr = addr_q;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_d = S_DONE;
          end else begin
            issue      = 1'b1;
            bram_raddr = base_addr;
            addr_d     = base_addr + ADDR_WIDTH'(1);
            remain_d   = count - (ADDR_WIDTH+1)'(1);
            state_d    = S_READ;
          end
        end
      end
      S_READ: begin
        busy = 1'b1;
        if (remain_q == '0) begin
          state_d = S_DRAIN;
        end else if (space_ok) begin
          issue    = 1'b1;
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - (ADDR_WIDTH+1)'(1);
          if (remain_q == (ADDR_WIDTH+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop && occ_q == 2'd1 && !inflight_q) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= issue;
      if (push) begin
        mem_q[wr_ptr_q] <= bram_rdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

`ifdef BRAM_STREAM_READER_LAST_EN
  logic [ADDR_WIDTH:0] beats_left_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_left_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      beats_left_q <= count;
    end else if (pop) begin
      beats_left_q <= beats_left_q - (ADDR_WIDTH+1)'(1);
    end
  end

  assign m_last = m_valid && (beats_left_q == (ADDR_WIDTH+1)'(1));
`endif

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of one BRAM word and one stream beat.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: BRAM address width; depth = 2^ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first BRAM address of the burst, sampled with start.
REQ-007 SHALL have port count  input  ADDR_WIDTH+1  number of words to read (0..2^ADDR_WIDTH), sampled with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last beat is accepted.
REQ-010 SHALL have port bram_raddr  output  ADDR_WIDTH  read address to the external BRAM.
REQ-011 SHALL have port bram_rdata  input  DATA_WIDTH  BRAM registered read data, valid one cycle after bram_raddr.
REQ-012 SHALL have port m_data  output  DATA_WIDTH  stream beat data.
REQ-013 SHALL have port m_valid  output  1  stream beat valid.
REQ-014 SHALL have port m_ready  input  1  downstream ready; beat transfers when m_valid and m_ready are both high.
REQ-015 SHALL have port m_last  output  1  marks final beat of the burst (present only per REQ-031).

Function
REQ-016 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-017 IDLE->READ on start with count>0; IDLE->DONE on start with count==0 (no beats, done pulse next cycle).
REQ-018 READ SHALL issue one read per cycle by presenting address on bram_raddr and marking it in flight, only while (buffer occupancy + in-flight) < 2.
REQ-019 Data returned on bram_rdata SHALL be captured exactly one cycle after the issue cycle into a 2-entry FIFO; no other bram_rdata cycles captured.
REQ-020 Addresses SHALL increment from base_addr modulo 2^ADDR_WIDTH (base 6, count 4, depth 8 -> 6,7,0,1).
REQ-021 READ->DRAIN when the count-th read is issued; DRAIN->DONE when the last beat transfers; DONE->IDLE after one cycle with done=1.
REQ-022 m_valid SHALL equal FIFO non-empty; m_data SHALL be FIFO head; beats emitted in address order, none dropped or duplicated.
REQ-023 m_data/m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 With m_ready held high, throughput SHALL be one beat per cycle; first beat m_valid SHALL rise 2 cycles after the start cycle.
REQ-025 Simultaneous FIFO push and pop at occupancy 1 or 2 SHALL leave occupancy unchanged and order intact.
REQ-026 start while not IDLE SHALL be ignored; base_addr/count changes mid-burst SHALL have no effect.
REQ-027 bram_raddr value when no read is issued is don't-care; the block never writes the BRAM.

Reset
REQ-028 rst=1 SHALL force IDLE, clear FIFO and in-flight flag; m_valid=0, busy=0, done=0, m_last=0, bram_raddr=0, m_data=0 on the following edge.
REQ-029 rst mid-burst SHALL abandon the burst; pending bram_rdata SHALL not be captured; no done pulse.
REQ-030 rst SHALL take priority over start in the same cycle.

Configuration
REQ-031 Macro BRAM_STREAM_READER_LAST_EN: when defined, port m_last exists and is high exactly with the count-th beat of each burst; when undefined, m_last port and its tracking logic are absent and all other behaviour is identical.

Verification
REQ-032 base 0, count 8, BRAM[i]=0x100+i, m_ready=1 -> 8 beats 0x100..0x107 in consecutive cycles, first valid at start+2, done once, m_last on 0x107 only.
REQ-033 base 6, count 4 -> raddr 6,7,0,1; beats BRAM[6],BRAM[7],BRAM[0],BRAM[1].
REQ-034 count 8, m_ready toggled 1,0,0,1,... -> all 8 beats in order, m_data stable during stalls, occupancy never exceeds 2.
REQ-035 count 0 -> no m_valid, done pulse one cycle after start, busy low throughout except as per REQ-008.
REQ-036 rst asserted after 3 of 8 beats -> m_valid=0 next cycle, no done, then new start base 2 count 2 -> beats BRAM[2],BRAM[3].
REQ-037 start pulsed again mid-burst with different base -> ignored; original burst completes unchanged.
